// File: rtl/sha1_pkg.sv
// Shared constants and state encoding for the sha1 arbiter slice.
package sha1_pkg;
    localparam int SHA1_BLOCK_W       = 512;
    localparam int SHA1_DIGEST_W      = 160;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;
endpackage

// File: rtl/sha1_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant wins.
module sha1_rr_pick #(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [1:0]      last_grant,
    output logic [NREQ-1:0] grant,
    output logic [1:0]      grant_id,
    output logic            any
);
    int idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            // last_grant < NREQ, so one wrap subtraction is enough
            idx = int'(last_grant) + 1 + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any && req_valid[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = 2'(idx);
            end
        end
    end
endmodule

// File: rtl/sha1_arbiter.sv
// Round-robin front end sharing one sha1 core between NREQ requesters.
// Optional watchdog enabled by defining SHA1_ARB_TIMEOUT_EN.
module sha1_arbiter
    import sha1_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*SHA1_BLOCK_W-1:0] req_block,
    output logic [NREQ-1:0]              req_ready,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [1:0]                   rsp_id,
    output logic [SHA1_DIGEST_W-1:0]     rsp_digest,
    output logic                         rsp_error,
    output logic                         busy,
    output logic                         core_reset,
    output logic                         core_on,
    output logic [SHA1_BLOCK_W-1:0]      core_message,
    input  logic [SHA1_DIGEST_W-1:0]     core_digest,
    input  logic                         core_finish
);
    if (NREQ < 1 || NREQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("sha1_arbiter: NREQ must be 1..4 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t      state;
    logic [1:0]      last_grant;
    logic [NREQ-1:0] pick_grant;
    logic [1:0]      pick_id;
    logic            pick_any;

    sha1_rr_pick #(.NREQ(NREQ)) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .grant_id   (pick_id),
        .any        (pick_any)
    );

    // Grant is only offered from IDLE and never while reset is held.
    assign req_ready  = (state == ST_IDLE && reset) ? pick_grant : '0;
    assign busy       = (state != ST_IDLE);
    assign rsp_valid  = (state == ST_RESP);
    assign core_on    = (state == ST_RUN);
    assign core_reset = (state != ST_RUN);

`ifdef SHA1_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] run_cnt;
    logic             err_q;
    assign rsp_error = err_q;
`else
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            last_grant   <= 2'(NREQ - 1);
            core_message <= '0;
            rsp_id       <= '0;
            rsp_digest   <= '0;
`ifdef SHA1_ARB_TIMEOUT_EN
            run_cnt      <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        core_message <= req_block[SHA1_BLOCK_W*pick_id +: SHA1_BLOCK_W];
                        rsp_id       <= pick_id;
                        last_grant   <= pick_id;
                        state        <= ST_RUN;
`ifdef SHA1_ARB_TIMEOUT_EN
                        run_cnt      <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    // finish has priority over a watchdog expiry in the same cycle
                    if (core_finish) begin
                        rsp_digest <= core_digest;
                        state      <= ST_RESP;
`ifdef SHA1_ARB_TIMEOUT_EN
                        err_q      <= 1'b0;
                    end else if (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_digest <= '0;
                        err_q      <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        run_cnt    <= run_cnt + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sha1_arbiter.sv
// Scoreboard bench for sha1_arbiter with a behavioural 85-cycle sha1 core model.
module tb_sha1_arbiter;
    import sha1_pkg::*;

    localparam int NREQ = 2;
    localparam int LAT  = 85;

    logic                         clk = 1'b0;
    logic                         reset = 1'b0;
    logic [NREQ-1:0]              req_valid = '0;
    logic [NREQ*SHA1_BLOCK_W-1:0] req_block = '0;
    logic [NREQ-1:0]              req_ready;
    logic                         rsp_valid;
    logic                         rsp_ready = 1'b1;
    logic [1:0]                   rsp_id;
    logic [SHA1_DIGEST_W-1:0]     rsp_digest;
    logic                         rsp_error;
    logic                         busy;
    logic                         core_reset;
    logic                         core_on;
    logic [SHA1_BLOCK_W-1:0]      core_message;
    logic [SHA1_DIGEST_W-1:0]     core_digest;
    logic                         core_finish;

    always #5 clk = ~clk;

    sha1_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(100)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_block    (req_block),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_digest   (rsp_digest),
        .rsp_error    (rsp_error),
        .busy         (busy),
        .core_reset   (core_reset),
        .core_on      (core_on),
        .core_message (core_message),
        .core_digest  (core_digest),
        .core_finish  (core_finish)
    );

    // core model: finish LAT cycles after on, digest = 5 copies of block[31:0]
    logic [7:0] mcnt = '0;
    logic       hang = 1'b0;
    logic       spur = 1'b0;
    always @(posedge clk) begin
        if (core_reset) mcnt <= '0;
        else if (core_on && mcnt != 8'hff) mcnt <= mcnt + 8'd1;
    end
    assign core_finish = (core_on && !hang && mcnt == 8'(LAT - 1)) || spur;
    assign core_digest = {5{core_message[31:0]}};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [1:0]               id;
        logic [SHA1_DIGEST_W-1:0] dig;
        logic                     err;
    } rsp_t;

    rsp_t                    exp_q[$];
    rsp_t                    item;
    logic [1:0]              m_last = 2'(NREQ - 1);
    logic [SHA1_BLOCK_W-1:0] cur_blk = '0;
    logic [NREQ-1:0]         eg;
    int                      gid;

    function automatic logic [NREQ-1:0] exp_grant(input logic [NREQ-1:0] v, input logic [1:0] last);
        logic [NREQ-1:0] g = '0;
        for (int k = 1; k <= NREQ; k++)
            if (g == '0 && v[(int'(last) + k) % NREQ]) g[(int'(last) + k) % NREQ] = 1'b1;
        return g;
    endfunction

    // scoreboard: push on grant, pop on response handshake
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            m_last = 2'(NREQ - 1);
        end else begin
            if ((!busy && req_valid != '0) || req_ready != '0) begin
                chk("grant_idle", busy, 1'b0);
                eg = exp_grant(req_valid, m_last);
                chk("grant", req_ready, eg);
                gid = 0;
                for (int i = 0; i < NREQ; i++) if (eg[i]) gid = i;
                item.id  = 2'(gid);
                item.err = hang;
                item.dig = hang ? '0 : {5{req_block[SHA1_BLOCK_W*gid +: 32]}};
                exp_q.push_back(item);
                cur_blk = req_block[SHA1_BLOCK_W*gid +: SHA1_BLOCK_W];
                m_last  = 2'(gid);
            end else if (busy && !rsp_valid) begin
                chk("core_msg", core_message, cur_blk);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    item = exp_q.pop_front();
                    chk("rsp_id", rsp_id, item.id);
                    chk("rsp_digest", rsp_digest, item.dig);
                    chk("rsp_error", rsp_error, item.err);
                end
            end
        end
    end

    task automatic wait_grant(output int t, output logic [NREQ-1:0] g);
        t = -1;
        g = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                t = cyc;
                g = req_ready;
                return;
            end
        end
        chk("grant_timeout", 1'b1, 1'b0);
    endtask

    task automatic wait_rsp(output int t);
        t = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                t = cyc;
                return;
            end
        end
        chk("rsp_timeout", 1'b1, 1'b0);
    endtask

    task automatic rand_block(input int id);
        for (int w = 0; w < 16; w++) req_block[SHA1_BLOCK_W*id + 32*w +: 32] = $urandom();
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, '0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({pfx, "_rsp_id"}, rsp_id, 2'd0);
        chk({pfx, "_rsp_digest"}, rsp_digest, '0);
        chk({pfx, "_rsp_error"}, rsp_error, 1'b0);
        chk({pfx, "_busy"}, busy, 1'b0);
        chk({pfx, "_core_reset"}, core_reset, 1'b1);
        chk({pfx, "_core_on"}, core_on, 1'b0);
        chk({pfx, "_core_message"}, core_message, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    int                      t0, t1, h, unstable, rdy, seen;
    logic [NREQ-1:0]         g;
    logic [1:0]              sid;
    logic [SHA1_DIGEST_W-1:0] sd;

    initial begin
        for (int r = 0; r < NREQ; r++) rand_block(r);
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        @(posedge clk); #1 reset = 1'b1;

        // spurious finish while idle
        spur = 1'b1;
        @(posedge clk); #1 spur = 1'b0;
        @(negedge clk);
        chk("spur_idle_busy", busy, 1'b0);
        chk("spur_idle_valid", rsp_valid, 1'b0);

        // single job, requester 0
        req_block[31:0] = 32'h61626380;
        req_valid = 2'b01;
        wait_grant(t0, g);
        chk("t1_grant", g, 2'b01);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        chk("t1_core_on", core_on, 1'b1);
        chk("t1_core_reset", core_reset, 1'b0);
        wait_rsp(t1);
        chk("t1_latency", t1 - t0, 86);
        chk("t1_id", rsp_id, 2'd0);
        chk("t1_digest", rsp_digest, {5{32'h61626380}});
        @(posedge clk); #1;

        // backpressure on requester 1's response, requester 0 waiting
        rsp_ready = 1'b0;
        req_valid = 2'b10;
        wait_grant(t0, g);
        chk("bp_grant", g, 2'b10);
        @(posedge clk); #1 req_valid = 2'b01;
        wait_rsp(t1);
        sid = rsp_id;
        sd  = rsp_digest;
        unstable = 0;
        rdy = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 spur = (i == 10);
            @(negedge clk);
            if (!rsp_valid || rsp_id != sid || rsp_digest != sd || rsp_error) unstable++;
            if (req_ready != '0) rdy++;
        end
        spur = 1'b0;
        chk("bp_stable", unstable, 0);
        chk("bp_no_ready", rdy, 0);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        h = cyc;
        chk("bp_hs_valid", rsp_valid, 1'b1);
        wait_grant(t0, g);
        chk("bp_next_grant", g, 2'b01);
        chk("bp_next_gap", t0 - h, 1);
        @(posedge clk); #1 req_valid = '0;

        // asynchronous reset at RUN cycle 40 of requester 0's job
        while (cyc < t0 + 40) @(negedge clk);
        chk("rst_pre_on", core_on, 1'b1);
        reset = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rst_no_rsp", seen, 0);
        @(posedge clk); #1;

        // contention: both requesters held valid over four jobs
        req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            wait_grant(t0, g);
            chk($sformatf("cont_grant%0d", j), g, (j % 2 == 0) ? 2'b01 : 2'b10);
            @(posedge clk); #1;
            rand_block((j % 2 == 0) ? 0 : 1);
        end
        req_valid = '0;
        wait_rsp(t1);
        @(posedge clk); #1;

`ifdef SHA1_ARB_TIMEOUT_EN
        // core never finishes: watchdog closes the job after 100 RUN cycles
        hang = 1'b1;
        req_valid = 2'b01;
        wait_grant(t0, g);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(t1);
        chk("wd_latency", t1 - t0, 101);
        chk("wd_error", rsp_error, 1'b1);
        chk("wd_digest", rsp_digest, '0);
        @(posedge clk); #1 hang = 1'b0;
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sha1_arbiter.md
# sha1_arbiter

Round-robin scheduler that lets up to four requesters share one `sha1` core. It accepts a 512-bit block from the granted requester and holds that block stable on the core's `message_in`. It then sequences the core's `reset`/`on` controls, waits for `finish`, and returns the 160-bit digest tagged with the requester ID over a valid/ready response channel. It sits between the host-side request ports and the single `sha1` instance, and its output `core_reset` is the only reset that instance receives.

## Interface
- `NREQ`, default 2: number of requesters, legal range 1..4.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in RUN cycles; only used when `SHA1_ARB_TIMEOUT_EN` is defined.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester block-valid flag.
- `req_block`  in  NREQ*512  block of requester i at bits [512*i+511 : 512*i].
- `req_ready`  out  NREQ  one-hot, one-cycle pulse: block of requester i accepted this cycle.
- `rsp_valid`  out  1  digest available.
- `rsp_ready`  in  1  consumer accepts the digest.
- `rsp_id`  out  2  index of the requester that owns the response.
- `rsp_digest`  out  160  digest captured from the core.
- `rsp_error`  out  1  job ended by watchdog; `rsp_digest` is 0.
- `busy`  out  1  high in every state except IDLE.
- `core_reset`  out  1  active-high synchronous reset to the core.
- `core_on`  out  1  drives the core `on` input.
- `core_message`  out  512  drives the core `message_in`.
- `core_digest`  in  160  core `digest_out`.
- `core_finish`  in  1  core `finish`.

## Operation
- FSM states are IDLE, RUN and RESP.
- IDLE:
  - `core_reset`=1, `core_on`=0.
  - If any `req_valid` bit is set, grant exactly one requester: pulse its `req_ready`, latch its block into `core_message`, record its ID, go to RUN.
- Arbitration is round-robin:
  - Search starts at (last_grant+1) mod NREQ.
  - After reset, last_grant = NREQ-1, so requester 0 has first priority.
  - last_grant updates only on a grant.
- RUN:
  - `core_reset`=0, `core_on`=1.
  - `core_message` is held constant for the whole job.
  - When `core_finish`=1 is sampled: capture `core_digest` into `rsp_digest`, set `rsp_error`=0, go to RESP.
- RESP:
  - `core_on`=0, `core_reset`=1, so the core is parked and cleared.
  - `rsp_valid`=1; `rsp_id`, `rsp_digest` and `rsp_error` stay stable until `rsp_valid`&&`rsp_ready`, then go to IDLE.
- `core_finish` is ignored outside RUN.
- `rsp_ready` is ignored while `rsp_valid`=0.
- A requester may drop `req_valid` before it is granted; this has no side effect.
- `req_block` is sampled only in the grant cycle.
- Reset asserted mid-operation: the job is abandoned and no response is produced. All outputs return to reset values immediately (asynchronous).
- Reset values of outputs:
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_digest`=0, `rsp_error`=0, `busy`=0.
  - `core_reset`=1, `core_on`=0, `core_message`=0.

## Timing
- Grant cycle T: `req_ready` pulses, block latched. At T+1, `core_on`=1 and `core_reset`=0.
- `core_finish` sampled high at cycle F gives `rsp_valid`=1 at F+1.
- Response handshake at cycle H gives IDLE at H+1. The earliest next grant is at H+1, so there is one dead cycle per job, which holds the core in reset.
- Latency request→response is 1 + core latency + 1 cycles; there is no fixed bound without the watchdog.

## Configuration
- `SHA1_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to RUN and increments every RUN cycle.
  - When it reaches `TIMEOUT_CYCLES` with no `core_finish`: go to RESP with `rsp_error`=1 and `rsp_digest`=0.
  - `core_finish` and the timeout in the same cycle: finish wins.
- `SHA1_ARB_TIMEOUT_EN` undefined:
  - No counter is built, and `rsp_error` is tied to 0.
  - RUN waits indefinitely for `core_finish`.

## Structure
- The shared package `sha1_pkg` holds:
  - `SHA1_BLOCK_W`=512 and `SHA1_DIGEST_W`=160.
  - The arbiter state enum (IDLE/RUN/RESP).
  - Default `TIMEOUT_CYCLES`.
- Sub-module `sha1_rr_pick`: combinational round-robin picker.
  - Inputs: `req_valid` and last_grant.
  - Outputs: one-hot grant and encoded ID.
- The FSM, latches and watchdog are in `sha1_arbiter`.

## Test plan
- The bench uses a behavioural core model that raises finish 85 cycles after `on`, with digest = {5{block[31:0]}}.
- Single job: req_valid=01, block[31:0]=32'h61626380 → `req_ready`=01 at T; `core_on` rises at T+1; `rsp_valid` at T+86 with `rsp_id`=0 and digest 5×32'h61626380.
- Contention: req_valid=11 held over 4 jobs → grant order 0,1,0,1; every `core_message` matches the granted block.
- Backpressure: `rsp_ready`=0 for 20 cycles after `rsp_valid` → outputs stable and no new `req_ready`; `rsp_ready`=1 → IDLE, next grant the following cycle.
- Reset mid-RUN (cycle 40 of a job) → all outputs go to reset values asynchronously and no response is produced; the next job proceeds normally with requester 0 first.
- With `SHA1_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100 and the model never finishing → `rsp_valid` with `rsp_error`=1 and digest 0 exactly 100 RUN cycles after entry to RUN.
- Spurious `core_finish` pulses in IDLE and RESP → no state change and no response.
